hc194_serial_tx: RTL and testbench
==================================

// Module: hc194_serial_tx
// PURPOSE
//  Serial transmitter that drives a 74HC194-style universal shift register used as a serial-in receiver.
//  Accepts a parallel word over a valid/ready handshake and generates the control pins S1/S0, the serial
//  pins Dsr/Dsl and an optional receiver clear, so the word appears on the receiver's Q after WIDTH shifts.
//  Sits between a word producer and an S_74HC194 on the same clock CP.
// PARAMETERS
//  WIDTH      4  bits per word; equals receiver register width (2..16)
//  CLR_FIRST  1  1: pulse rx_clr_n low for one cycle before shifting; 0: no clear phase
// PORTS
//  CP         in   1      clock; all state updates on rising edge
//  CR         in   1      asynchronous active-low reset
//  D          in   WIDTH  word to send; sampled on accept
//  dir        in   1      0 = shift right via Dsr, 1 = shift left via Dsl; sampled on accept
//  load_valid in   1      producer has a word
//  load_ready out  1      block can accept (high only in IDLE)
//  abort      in   1      cancel frame in progress
//  S1, S0     out  1 each receiver mode: 00 hold, 01 shift right, 10 shift left (11 never driven)
//  Dsr        out  1      serial data for right shift
//  Dsl        out  1      serial data for left shift
//  rx_clr_n   out  1      active-low clear to receiver CR
//  busy       out  1      high from accept until return to IDLE
//  done       out  1      one-cycle pulse: receiver Q now holds the word
// BEHAVIOUR
//  - All outputs registered. Reset (CR low, async): state IDLE, S1S0=00, Dsr=Dsl=0, rx_clr_n=1,
//    busy=0, done=0, load_ready=1, shift reg and bit counter 0.
//  - States: IDLE -> (CLEAR if CLR_FIRST) -> SHIFT -> DONE -> IDLE.
//  - IDLE: S1S0=00, Dsr=Dsl=0. Accept on edge where load_valid&load_ready: latch D and dir, busy=1.
//  - CLEAR: exactly one cycle, rx_clr_n=0, S1S0=00; then SHIFT.
//  - SHIFT: exactly WIDTH cycles. dir=0: S1S0=01, Dsr carries D[WIDTH-1] first down to D[0], Dsl=0.
//    dir=1: S1S0=10, Dsl carries D[0] first up to D[WIDTH-1], Dsr=0. Bit counter 0..WIDTH-1;
//    exits on count WIDTH-1 (no wrap past WIDTH).
//  - DONE: one cycle, S1S0=00, done=1, busy=1, load_ready=0; Dsr=Dsl=0. Then IDLE.
//  - Latency (CLR_FIRST=1): accept at edge k; clear cycle k..k+1; receiver samples bits on edges
//    k+2..k+WIDTH+1; done high in cycle after edge k+WIDTH+1. CLR_FIRST=0: one cycle less.
//  - abort in CLEAR or SHIFT: next edge -> IDLE, S1S0=00, rx_clr_n=1, no done pulse, word discarded.
//    abort in IDLE/DONE ignored. abort and load_valid together in IDLE: accept (abort ignored).
//  - load_valid while busy ignored; D/dir changes after accept have no effect.
//  - CR asserted mid-frame: immediate return to reset values; receiver contents undefined.
//  - Mode 11 (parallel load) never generated; S1S0 never 11 in any cycle, including transitions.
// STRUCTURE
//  - Shared package hc194_pkg: mode constants MODE_HOLD=2'b00, MODE_SHR=2'b01, MODE_SHL=2'b10,
//    MODE_LOAD=2'b11; state encoding ST_IDLE, ST_CLEAR, ST_SHIFT, ST_DONE.
//  - One sub-module hc194_piso_core: WIDTH-bit shift register + bit counter with load/shift/last
//    outputs, direction-selectable serial out; FSM and pin registers stay in top.
// TESTING (bench instantiates S_74HC194 as receiver, CP period 100 ns, WIDTH=4)
//  - Reset: CR low 20 ns mid-cycle -> all outputs at reset values immediately; load_ready=1.
//  - dir=0, D=4'b1011, CLR_FIRST=1 -> rx_clr_n low 1 cycle, Dsr 1,0,1,1 with S1S0=01, done; Q=1011.
//  - dir=1, D=4'b0110 -> Dsl 0,1,1,0 with S1S0=10; done; Q=0110; Q unchanged 3 cycles after (hold).
//  - Back-to-back: load_valid held, D=1111 then 0001 -> second accept only in IDLE after DONE; Q=0001.
//  - abort on 2nd SHIFT cycle -> IDLE next edge, no done, S1S0=00; new word 1100 then sends cleanly.
//  - CR pulsed low mid-SHIFT -> outputs reset asynchronously; S1S0 never observed as 11 in any run.

Source files
------------

// File: rtl/hc194_pkg.sv
// Shared definitions for the 74HC194 serial transmitter.
//  - Receiver mode codes driven on {S1,S0}.
//  - FSM state encoding for the transmitter.
//  - Helper that maps a shift direction to its receiver mode.
package hc194_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_CLEAR = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  // dir=0 shifts right through Dsr, dir=1 shifts left through Dsl
  function automatic logic [1:0] shift_mode(input logic dir);
    logic [1:0] m;
    if (dir) begin
      m = MODE_SHL;
    end else begin
      m = MODE_SHR;
    end
    return m;
  endfunction

endpackage

// File: rtl/hc194_piso_core.sv
// Parallel-in serial-out core: holds the word being sent plus the count of
// bits emitted during the shift phase.
// Ports:
//  clk, rst_n   clock, async active-low reset
//  load         capture d/dir and clear the bit counter
//  shift        advance the word by one bit (with load: store d pre-advanced)
//  count        increment the bit counter
//  d, dir       word and direction presented for load
//  ser_out      bit currently at the output end of the stored word
//  load_bit     bit that d/dir would send first (used on the accept edge)
//  dir_q        latched direction
//  last         counter has reached WIDTH-1
module hc194_piso_core
  import hc194_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic             count,
  input  logic [WIDTH-1:0] d,
  input  logic             dir,
  output logic             ser_out,
  output logic             load_bit,
  output logic             dir_q,
  output logic             last
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] shreg_r;
  logic [CW-1:0]    cnt_r;
  logic             dir_r;

  // Right shift of the receiver consumes MSB first, left shift consumes LSB first
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v, input logic left);
    logic [WIDTH-1:0] r;
    if (left) begin
      r = {1'b0, v[WIDTH-1:1]};
    end else begin
      r = {v[WIDTH-2:0], 1'b0};
    end
    return r;
  endfunction

  // Word, direction and bit-counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_r <= {WIDTH{1'b0}};
      cnt_r   <= {CW{1'b0}};
      dir_r   <= 1'b0;
    end else if (load) begin
      shreg_r <= shift ? advance(d, dir) : d;
      dir_r   <= dir;
      cnt_r   <= {CW{1'b0}};
    end else begin
      if (shift) begin
        shreg_r <= advance(shreg_r, dir_r);
      end
      if (count) begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

  assign ser_out  = dir_r ? shreg_r[0] : shreg_r[WIDTH-1];
  assign load_bit = dir ? d[0] : d[WIDTH-1];
  assign dir_q    = dir_r;
  assign last     = (cnt_r == CW'(WIDTH - 1));

endmodule

// File: rtl/hc194_serial_tx.sv
// Serial transmitter driving a 74HC194 used as a serial-in receiver on the
// same clock. A word accepted over load_valid/load_ready is optionally
// preceded by a one-cycle receiver clear, then shifted in over WIDTH cycles.
// Ports:
//  CP, CR            clock, async active-low reset
//  D, dir            word and direction, sampled on accept
//  load_valid/ready  producer handshake (ready only in IDLE)
//  abort             cancel a frame in CLEAR or SHIFT
//  S1, S0            receiver mode (never 11)
//  Dsr, Dsl          receiver serial inputs
//  rx_clr_n          receiver clear
//  busy, done        frame in progress / receiver holds the word
module hc194_serial_tx
  import hc194_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit CLR_FIRST = 1'b1
) (
  input  logic             CP,
  input  logic             CR,
  input  logic [WIDTH-1:0] D,
  input  logic             dir,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             abort,
  output logic             S1,
  output logic             S0,
  output logic             Dsr,
  output logic             Dsl,
  output logic             rx_clr_n,
  output logic             busy,
  output logic             done
);

  state_t     state_r, state_nxt_s;
  logic [1:0] mode_r, mode_nxt_s;
  logic       dsr_r, dsr_nxt_s, dsl_r, dsl_nxt_s;
  logic       clr_n_r, busy_r, done_r, ready_r;
  logic       accept_s, shift_s, count_s, bit_s, dir_sel_s;
  logic       ser_out_s, load_bit_s, dir_q_s, last_s;

  assign accept_s = load_valid & ready_r;

  hc194_piso_core #(.WIDTH(WIDTH)) u_core (
    .clk      (CP),
    .rst_n    (CR),
    .load     (accept_s),
    .shift    (shift_s),
    .count    (count_s),
    .d        (D),
    .dir      (dir),
    .ser_out  (ser_out_s),
    .load_bit (load_bit_s),
    .dir_q    (dir_q_s),
    .last     (last_s)
  );

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = CLR_FIRST ? ST_CLEAR : ST_SHIFT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (abort) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          state_nxt_s = ST_IDLE;
        end else if (last_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      ST_DONE:  state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // Pin values for the coming cycle, derived from the state being entered.
  // On the accept edge the word is not yet in the core, so the first bit
  // and direction come straight from the inputs.
  always_comb begin
    shift_s    = (state_nxt_s == ST_SHIFT);
    count_s    = shift_s && (state_r == ST_SHIFT);
    bit_s      = (state_r == ST_IDLE) ? load_bit_s : ser_out_s;
    dir_sel_s  = (state_r == ST_IDLE) ? dir : dir_q_s;
    mode_nxt_s = MODE_HOLD;
    dsr_nxt_s  = 1'b0;
    dsl_nxt_s  = 1'b0;
    if (shift_s) begin
      mode_nxt_s = shift_mode(dir_sel_s);
      if (dir_sel_s) begin
        dsl_nxt_s = bit_s;
      end else begin
        dsr_nxt_s = bit_s;
      end
    end else begin
      mode_nxt_s = MODE_HOLD;
    end
  end

  // State and output pin registers
  always_ff @(posedge CP or negedge CR) begin
    if (!CR) begin
      state_r <= ST_IDLE;
      mode_r  <= MODE_HOLD;
      dsr_r   <= 1'b0;
      dsl_r   <= 1'b0;
      clr_n_r <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      ready_r <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      mode_r  <= mode_nxt_s;
      dsr_r   <= dsr_nxt_s;
      dsl_r   <= dsl_nxt_s;
      clr_n_r <= (state_nxt_s != ST_CLEAR);
      busy_r  <= (state_nxt_s != ST_IDLE);
      done_r  <= (state_nxt_s == ST_DONE);
      ready_r <= (state_nxt_s == ST_IDLE);
    end
  end

  assign S1         = mode_r[1];
  assign S0         = mode_r[0];
  assign Dsr        = dsr_r;
  assign Dsl        = dsl_r;
  assign rx_clr_n   = clr_n_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign load_ready = ready_r;

endmodule

// File: tb/tb_hc194_serial_tx.sv
// Directed bench for hc194_serial_tx (WIDTH=4, CLR_FIRST=1) with a
// behavioural 74HC194 receiver modelled on the same clock.
module tb_hc194_serial_tx;

  logic       CP, CR, dir, load_valid, load_ready, abort;
  logic [3:0] D;
  logic       S1, S0, Dsr, Dsl, rx_clr_n, busy, done;
  logic [3:0] q;
  logic       seen11;
  int         n_assert, n_fail;

  hc194_serial_tx #(.WIDTH(4), .CLR_FIRST(1'b1)) dut (
    .CP(CP), .CR(CR), .D(D), .dir(dir), .load_valid(load_valid),
    .load_ready(load_ready), .abort(abort), .S1(S1), .S0(S0),
    .Dsr(Dsr), .Dsl(Dsl), .rx_clr_n(rx_clr_n), .busy(busy), .done(done)
  );

  initial begin
    CP = 1'b0;
    forever #50 CP = ~CP;
  end

  // 74HC194 receiver: Q = {Q3,Q2,Q1,Q0}; shift right moves Q0->Q3 with Dsr into Q0
  always @(posedge CP or negedge rx_clr_n) begin
    if (!rx_clr_n) q <= 4'b0000;
    else begin
      case ({S1, S0})
        2'b01:   q <= {q[2:0], Dsr};
        2'b10:   q <= {Dsl, q[3:1]};
        2'b11:   q <= D;
        default: q <= q;
      endcase
    end
  end

  initial seen11 = 1'b0;
  always @(S1 or S0) if (S1 === 1'b1 && S0 === 1'b1) seen11 = 1'b1;

  // {S1,S0,Dsr,Dsl,rx_clr_n,busy,done,load_ready}
  localparam logic [7:0] P_IDLE  = 8'b0000_1001;
  localparam logic [7:0] P_CLEAR = 8'b0000_0100;
  localparam logic [7:0] P_DONE  = 8'b0000_1110;

  function automatic logic [7:0] p_shr(input logic b);
    return {2'b01, b, 1'b0, 4'b1100};
  endfunction
  function automatic logic [7:0] p_shl(input logic b);
    return {2'b10, 1'b0, b, 4'b1100};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CP);
    #1;
  endtask

  task automatic pins(input string tag, input logic [7:0] exp);
    chk(tag, {S1, S0, Dsr, Dsl, rx_clr_n, busy, done, load_ready}, exp);
  endtask

  initial begin
    n_assert = 0; n_fail = 0;
    CR = 1'b1; D = 4'b0000; dir = 1'b0; load_valid = 1'b0; abort = 1'b0;

    // Reset pulse, 20 ns, mid-cycle
    #20 CR = 1'b0;
    #1  pins("reset_async", P_IDLE);
    #19 CR = 1'b1;
    tick();
    pins("idle_after_reset", P_IDLE);

    // Right shift of 1011
    D = 4'b1011; dir = 1'b0; load_valid = 1'b1;
    tick(); pins("r_clear", P_CLEAR);
    load_valid = 1'b0; D = 4'b0000; dir = 1'b1;
    tick(); pins("r_b3", p_shr(1'b1));
    tick(); pins("r_b2", p_shr(1'b0));
    tick(); pins("r_b1", p_shr(1'b1));
    tick(); pins("r_b0", p_shr(1'b1));
    tick(); pins("r_done", P_DONE);
    chk("r_q", {4'b0000, q}, 8'h0B);
    tick(); pins("r_idle", P_IDLE);

    // Left shift of 0110, then hold
    D = 4'b0110; dir = 1'b1; load_valid = 1'b1;
    tick(); pins("l_clear", P_CLEAR);
    load_valid = 1'b0;
    tick(); pins("l_b0", p_shl(1'b0));
    tick(); pins("l_b1", p_shl(1'b1));
    tick(); pins("l_b2", p_shl(1'b1));
    tick(); pins("l_b3", p_shl(1'b0));
    tick(); pins("l_done", P_DONE);
    chk("l_q", {4'b0000, q}, 8'h06);
    tick(); tick(); tick();
    pins("l_idle_hold", P_IDLE);
    chk("l_q_hold", {4'b0000, q}, 8'h06);

    // Back-to-back with load_valid held
    D = 4'b1111; dir = 1'b0; load_valid = 1'b1;
    tick(); pins("bb1_clear", P_CLEAR);
    D = 4'b0001;
    tick(); pins("bb1_b3", p_shr(1'b1));
    tick(); pins("bb1_b2", p_shr(1'b1));
    tick(); pins("bb1_b1", p_shr(1'b1));
    tick(); pins("bb1_b0", p_shr(1'b1));
    tick(); pins("bb1_done", P_DONE);
    chk("bb1_q", {4'b0000, q}, 8'h0F);
    tick(); pins("bb_idle_gap", P_IDLE);
    tick(); pins("bb2_clear", P_CLEAR);
    load_valid = 1'b0;
    tick(); pins("bb2_b3", p_shr(1'b0));
    tick(); pins("bb2_b2", p_shr(1'b0));
    tick(); pins("bb2_b1", p_shr(1'b0));
    tick(); pins("bb2_b0", p_shr(1'b1));
    tick(); pins("bb2_done", P_DONE);
    chk("bb2_q", {4'b0000, q}, 8'h01);
    tick(); pins("bb2_idle", P_IDLE);

    // Abort on the second SHIFT cycle
    D = 4'b1010; dir = 1'b0; load_valid = 1'b1;
    tick(); pins("ab_clear", P_CLEAR);
    load_valid = 1'b0;
    tick(); pins("ab_b3", p_shr(1'b1));
    tick(); pins("ab_b2", p_shr(1'b0));
    abort = 1'b1;
    tick(); pins("ab_idle", P_IDLE);
    abort = 1'b0;
    tick(); pins("ab_no_done", P_IDLE);

    // New word 1100; abort raised together with load_valid in IDLE is ignored
    D = 4'b1100; dir = 1'b0; load_valid = 1'b1; abort = 1'b1;
    tick(); pins("n_clear", P_CLEAR);
    load_valid = 1'b0; abort = 1'b0;
    tick(); pins("n_b3", p_shr(1'b1));
    tick(); pins("n_b2", p_shr(1'b1));
    tick(); pins("n_b1", p_shr(1'b0));
    tick(); pins("n_b0", p_shr(1'b0));
    tick(); pins("n_done", P_DONE);
    chk("n_q", {4'b0000, q}, 8'h0C);
    tick(); pins("n_idle", P_IDLE);

    // CR pulse mid-SHIFT
    D = 4'b0101; dir = 1'b1; load_valid = 1'b1;
    tick(); pins("cr_clear", P_CLEAR);
    load_valid = 1'b0;
    tick(); pins("cr_b0", p_shl(1'b1));
    #25 CR = 1'b0;
    #1  pins("cr_async", P_IDLE);
    #19 CR = 1'b1;
    tick(); pins("cr_idle", P_IDLE);

    chk("never_mode11", {7'b0000000, seen11}, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
